// File: rtl/serial_arith_pkg.sv
// Shared definitions for bit-serial arithmetic blocks (subtractor now, adder later).
package serial_arith_pkg;

    localparam int unsigned SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor: difference and borrow-out of A - B - B_in.
module Full_subtractor (
    input  logic A,
    input  logic B,
    input  logic B_in,
    output logic D,
    output logic B_out
);

    assign D     = A ^ B ^ B_in;
    assign B_out = (~A & B) | (~(A ^ B) & B_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - B_in one bit per cycle, LSB first,
// reporting the difference, final borrow and signed overflow.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_in,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] D,
    output logic             B_out,
    output logic             V
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             bout_q, bout_d, v_q, v_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             fs_d, fs_bout;

    Full_subtractor u_full_sub (
        .A     (a_q[0]),
        .B     (b_q[0]),
        .B_in  (borrow_q),
        .D     (fs_d),
        .B_out (fs_bout)
    );

    // Next-state, datapath and output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        bout_d   = bout_q;
        v_d      = v_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    a_d      = A;
                    b_d      = B;
                    borrow_d = B_in;
                    // Sign bits shift out of the operand registers, so keep them aside
                    a_msb_d  = A[WIDTH-1];
                    b_msb_d  = B[WIDTH-1];
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = fs_bout;
                d_d      = {fs_d, d_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    bout_d  = fs_bout;
                    v_d     = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            bout_q   <= 1'b0;
            v_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            bout_q   <= bout_d;
            v_q      <= v_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy  = busy_q;
    assign Done  = done_q;
    assign D     = d_q;
    assign B_out = bout_q;
    assign V     = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed table, corner sequences, random ops.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Start;
    logic [W-1:0] A, B;
    logic         B_in;
    logic         Busy, Done, B_out, V;
    logic [W-1:0] D;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .A     (A),
        .B     (B),
        .B_in  (B_in),
        .Busy  (Busy),
        .Done  (Done),
        .D     (D),
        .B_out (B_out),
        .V     (V)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         v;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for D/borrow and signed range test for V
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                  output logic [W-1:0] d, output logic bo, output logic v);
        int unsigned ua = a;
        int unsigned ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int diff = sa - sb - int'(bin);
        d  = W'(ua - ub - int'(bin));
        bo = (ua < ub + int'(bin));
        v  = (diff < -(2 ** (W - 1))) || (diff > (2 ** (W - 1)) - 1);
    endfunction

    // One full operation from IDLE/DONE with exact timing and result checks
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] ed, input logic eb, input logic ev, input string tag);
        int bad = 0;
        @(negedge CLK);
        Start = 1'b1; A = a; B = b; B_in = bin;
        for (int j = 1; j <= W; j++) begin
            @(negedge CLK);
            if (j == 1) begin
                Start = 1'b0; A = ~a; B = W'($urandom); B_in = ~bin;
            end
            if (Busy !== 1'b1 || Done !== 1'b0) bad++;
        end
        check({tag, "_busy_window"}, 32'(bad), 32'd0);
        @(negedge CLK);
        check({tag, "_done"}, {30'd0, Done, Busy}, 32'h2);
        check({tag, "_d"}, 32'(D), 32'(ed));
        check({tag, "_bout_v"}, {30'd0, B_out, V}, {30'd0, eb, ev});
    endtask

    vec_t vecs[7];

    initial begin
        logic [W-1:0] ed, hold_d;
        logic         eb, ev;
        int           cnt, bad;
        logic [W-1:0] ba[3], bb[3];

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};

        RST = 1'b1; Start = 1'b0; A = '0; B = '0; B_in = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_ctrl", {30'd0, Busy, Done}, 32'd0);
        check("reset_d", 32'(D), 32'd0);
        check("reset_bout_v", {30'd0, B_out, V}, 32'd0);
        RST = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].v, "vec");
        end

        // Results hold through IDLE
        hold_d = D;
        bad = 0;
        repeat (4) begin
            @(negedge CLK);
            if (Done !== 1'b0 || Busy !== 1'b0 || D !== hold_d) bad++;
        end
        check("idle_hold", 32'(bad), 32'd0);

        // Start re-pulsed during SHIFT cycle 3 is ignored
        @(negedge CLK);
        Start = 1'b1; A = 8'h05; B = 8'h03; B_in = 1'b0;
        cnt = 0;
        for (int j = 1; j <= W + 4; j++) begin
            @(negedge CLK);
            if (j == 1) Start = 1'b0;
            if (j == 3) begin Start = 1'b1; A = 8'hFF; B = 8'h00; end
            if (j == 4) Start = 1'b0;
            if (Done === 1'b1) begin
                cnt++;
                check("ignore_start_d", 32'(D), 32'h02);
                check("ignore_start_time", 32'(j), 32'(W + 1));
            end
        end
        check("ignore_start_done_count", 32'(cnt), 32'd1);
        check("ignore_start_idle", {31'd0, Busy}, 32'd0);

        // Reset in SHIFT cycle 4 aborts with no Done
        @(negedge CLK);
        Start = 1'b1; A = 8'hAA; B = 8'h11; B_in = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge CLK);
            if (j == 1) Start = 1'b0;
        end
        RST = 1'b1;
        #1;
        check("abort_busy_done", {30'd0, Busy, Done}, 32'd0);
        check("abort_d", 32'(D), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        cnt = 0;
        repeat (W + 3) begin
            @(negedge CLK);
            if (Done !== 1'b0 || Busy !== 1'b0) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, "after_abort");

        // Start held high: back-to-back ops, Done every W+1 cycles
        ba[0] = 8'h33; bb[0] = 8'h11;
        ba[1] = 8'h50; bb[1] = 8'h20;
        ba[2] = 8'h01; bb[2] = 8'h02;
        @(negedge CLK);
        Start = 1'b1; A = ba[0]; B = bb[0]; B_in = 1'b0;
        bad = 0;
        for (int c = 1; c <= 3 * (W + 1); c++) begin
            @(negedge CLK);
            if (Done !== (c % (W + 1) == 0) || Busy !== !(c % (W + 1) == 0)) bad++;
            if (c % (W + 1) == 0) begin
                model(ba[c / (W + 1) - 1], bb[c / (W + 1) - 1], 1'b0, ed, eb, ev);
                check("b2b_d", 32'(D), 32'(ed));
                if (c / (W + 1) < 3) begin
                    A = ba[c / (W + 1)]; B = bb[c / (W + 1)];
                end else begin
                    Start = 1'b0;
                end
            end
        end
        check("b2b_timing", 32'(bad), 32'd0);

        // Random operations against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            logic         rbin;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom_range(0, 1));
            model(ra, rb, rbin, ed, eb, ev);
            run_op(ra, rb, rbin, ed, eb, ev, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
